// File: rtl/m_proc_mc.sv
// m_proc_mc: multi-cycle MIPS-32 subset processor (IF/ID/EX/MEM/WB) with internal memories.
// Define M_PROC_MC_MUL_EN to enable R-type funct 6'h18 (mul).
module m_proc_mc_ram #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd
);
  logic [31:0] cm_ram [2**AW];
  always_ff @(posedge i_clk)
    if (i_we) cm_ram[i_addr] <= i_wd;
  assign o_rd = cm_ram[i_addr];
endmodule

module m_proc_mc #(
  parameter int          IMEM_AW  = 12,
  parameter int          DMEM_AW  = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic [31:0] w_led,
  output logic        w_retire,
  output logic        w_halt,
  output logic [31:0] w_pc
);
`ifdef M_PROC_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_state_n;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_led;
  logic [31:0] r_rf [32];
  logic [31:0] w_imem_rd, w_dmem_rd, w_imm, w_alu, w_wb_data;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rdf, w_wb_dst;
  logic        w_mul, w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_halt, w_valid;
  logic        w_rf_we, w_dm_we;

  m_proc_mc_ram #(.AW(IMEM_AW)) m_imem (
    .i_clk(w_clk), .i_we(1'b0), .i_addr(r_pc[IMEM_AW+1:2]), .i_wd(32'h0), .o_rd(w_imem_rd)
  );
  m_proc_mc_ram #(.AW(DMEM_AW)) m_dmem (
    .i_clk(w_clk), .i_we(w_dm_we), .i_addr(r_alu[DMEM_AW+1:2]), .i_wd(r_b), .o_rd(w_dmem_rd)
  );

  assign w_op      = r_ir[31:26];
  assign w_fn      = r_ir[5:0];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rdf     = r_ir[15:11];
  assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_mul     = MUL_EN && w_fn == 6'h18;
  assign w_is_r    = w_op == 6'h00 && (w_fn == 6'h20 || w_fn == 6'h22 || w_fn == 6'h24 ||
                     w_fn == 6'h25 || w_fn == 6'h2a || w_mul);
  assign w_is_addi = w_op == 6'h08;
  assign w_is_lw   = w_op == 6'h23;
  assign w_is_sw   = w_op == 6'h2b;
  assign w_is_beq  = w_op == 6'h04;
  assign w_is_halt = w_op == 6'h3f;
  assign w_valid   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq;
  // Non-R-type ALU users (addi/lw/sw) all need base + immediate
  assign w_alu = w_op != 6'h00 ? r_a + w_imm :
                 w_fn == 6'h22 ? r_a - r_b :
                 w_fn == 6'h24 ? r_a & r_b :
                 w_fn == 6'h25 ? r_a | r_b :
                 w_fn == 6'h2a ? {31'h0, $signed(r_a) < $signed(r_b)} :
                 w_mul         ? r_a * r_b : r_a + r_b;
  assign w_wb_dst  = w_op == 6'h00 ? w_rdf : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu;

  always_comb begin
    w_state_n = r_state;
    w_retire  = 1'b0;
    w_rf_we   = 1'b0;
    w_dm_we   = 1'b0;
    case (r_state)
      S_IF:  w_state_n = S_ID;
      S_ID: begin
        w_state_n = w_is_halt ? S_HALT : w_valid ? S_EX : S_IF;
        w_retire  = !w_valid;
      end
      S_EX: begin
        w_state_n = w_is_beq ? S_IF : (w_is_lw | w_is_sw) ? S_MEM : S_WB;
        w_retire  = w_is_beq;
      end
      S_MEM: begin
        w_state_n = w_is_lw ? S_WB : S_IF;
        w_retire  = w_is_sw;
        w_dm_we   = w_is_sw && !w_rst;
      end
      S_WB: begin
        w_state_n = S_IF;
        w_retire  = 1'b1;
        w_rf_we   = w_wb_dst != 5'd0;
      end
      default: ;
    endcase
    w_retire = w_retire && !w_rst;
  end

  always_ff @(posedge w_clk)
    if (w_rst) r_state <= S_IF;
    else r_state <= w_state_n;

  always_ff @(posedge w_clk)
    if (w_rst) begin
      r_pc  <= RESET_PC;
      r_led <= 32'h0;
    end else begin
      if (r_state == S_IF) begin
        r_ir <= w_imem_rd;
        r_pc <= r_pc + 32'd4;
      end
      if (r_state == S_ID) begin
        r_a <= w_rs == 5'd0 ? 32'h0 : r_rf[w_rs];
        r_b <= w_rt == 5'd0 ? 32'h0 : r_rf[w_rt];
      end
      if (r_state == S_EX) begin
        r_alu <= w_alu;
        if (w_is_beq && r_a == r_b) r_pc <= r_pc + (w_imm << 2);
      end
      if (r_state == S_MEM) r_mdr <= w_dmem_rd;
      if (w_rf_we) begin
        r_rf[w_wb_dst] <= w_wb_data;
        r_led          <= w_wb_data;
      end
    end

  assign w_led  = r_led;
  assign w_halt = r_state == S_HALT;
  assign w_pc   = r_pc;
endmodule
